mult_with_no_sm: RTL and testbench
==================================

Name: mult_with_no_sm

Overview:
- Datapath of a signed radix-2 Booth multiplier with no internal state machine.
- An external controller sequences it through the 5-bit mult_control word.
- The controller reads the current Booth bit pair on Q_LSB.
- The finished 2N-bit product is registered onto Y.

Parameters:
- N, 8, operand width in bits. A and B are N-bit two's complement; Y is 2N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  N  multiplicand, signed.
- B  input  N  multiplier, signed.
- mult_control  input  5  per-cycle command word, bits defined below.
- Q_LSB  output  2  Booth pair {Q[0], Q_1}, combinational from registers.
- Y  output  2N  registered product, signed.

Interface (already decided):
- One clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Internal registers:
  - M: N+1 bits, sign-extended multiplicand.
  - ACC: N+1 bits, accumulator. The extra bit makes the -2^(N-1) multiplicand correct.
  - Q: N bits, multiplier/low product.
  - Q_1: 1 bit.
  - Y: 2N bits.
- Reset (rst=1 at a clock edge): M, ACC, Q, Q_1 and Y all go to 0, so Q_LSB=2'b00. Reset overrides every mult_control bit and may occur mid-operation.
- mult_control bit meanings:
  - [0] load: M <= sign-extended A; Q <= B; ACC <= 0; Q_1 <= 0.
  - [1] add: ACC <= ACC + M.
  - [2] sub: ACC <= ACC - M.
  - [3] shift: arithmetic right shift of {ACC,Q,Q_1} by 1. ACC MSB is replicated; ACC[0] goes to Q[N-1]; Q[0] goes to Q_1.
  - [4] out_en: Y <= {ACC[N-1:0], Q}, taken from the register values before this edge's updates.
- Priority and combinations, in one edge:
  - load set: the other arithmetic/shift bits are ignored. out_en still captures the old values.
  - add and sub both set: no arithmetic (ACC unchanged). Shift still applies if bit [3] is set.
  - add or sub together with shift: the shift acts on the post-add/sub ACC, giving a full Booth step in one cycle.
  - mult_control=0: all registers hold.
- Arithmetic is modulo 2^(N+1) on ACC. With the N+1 accumulator, no Booth step can overflow for any pair of N-bit operands.
- Intended controller sequence (not enforced by the block):
  - One load cycle.
  - N step cycles, each selecting by Q_LSB: 01 = add+shift, 10 = sub+shift, 00 or 11 = shift only.
  - One out_en cycle.
- Y holds its value until the next out_en or reset.
- Latency with that sequence: N+2 cycles from load to a valid Y. Y is visible the cycle after the out_en edge.
- Q_LSB changes only on clock edges. It carries no combinational path from mult_control.
- Target implementation size: roughly 120-200 lines of RTL.

Test Plan:
- Reset: rst=1 for 2 edges with random mult_control → Y=16'h0000, Q_LSB=2'b00; registers hold at 0 after rst deasserts with mult_control=0.
- Positive product: A=3, B=5, bench drives the Booth sequence from Q_LSB → after out_en, Y=16'h000F.
- Mixed sign: A=-3 (8'hFD), B=5 → Y=16'hFFF1. Also A=127, B=-128 → Y=16'hC080.
- Corner: A=-128, B=-128 → Y=16'h4000; A=0, B=-1 → Y=16'h0000.
- Control rules:
  - After load with B=8'h01, Q_LSB=2'b10.
  - add+sub together with shift leaves ACC unchanged and still shifts.
  - load together with add loads only.
- Reset mid-operation: assert rst after 4 steps → next cycle Y=0 and Q_LSB=0; a fresh multiply 7×(-2) then gives Y=16'hFFF2.

Source files
------------

// File: rtl/mult_with_no_sm.sv
// Signed radix-2 Booth multiplier datapath with no internal sequencer.
// An external controller drives mult_control each cycle and reads the Booth pair on Q_LSB.
module mult_with_no_sm #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [4:0]       mult_control,
    output logic [1:0]       Q_LSB,
    output logic [2*N-1:0]   Y
);

    logic signed [N:0]   r_m;
    logic signed [N:0]   r_acc;
    logic [N-1:0]        r_q;
    logic                r_q1;
    logic [2*N-1:0]      r_y;

    logic                w_load;
    logic                w_add;
    logic                w_sub;
    logic                w_shift;
    logic                w_out_en;
    logic signed [N:0]   w_acc_arith;
    logic signed [N:0]   w_acc_next;
    logic [N-1:0]        w_q_next;
    logic                w_q1_next;

    assign w_load   = mult_control[0];
    assign w_add    = mult_control[1];
    assign w_sub    = mult_control[2];
    assign w_shift  = mult_control[3];
    assign w_out_en = mult_control[4];

    // Add and sub together cancel; the shift then acts on the post-arithmetic accumulator.
    always_comb begin
        w_acc_arith = r_acc;
        w_acc_next  = r_acc;
        w_q_next    = r_q;
        w_q1_next   = r_q1;
        case ({w_sub, w_add})
            2'b01:   w_acc_arith = r_acc + r_m;
            2'b10:   w_acc_arith = r_acc - r_m;
            default: w_acc_arith = r_acc;
        endcase
        w_acc_next = w_acc_arith;
        if (w_shift) begin
            w_acc_next = w_acc_arith >>> 1;
            w_q_next   = {w_acc_arith[0], r_q[N-1:1]};
            w_q1_next  = r_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_y   <= '0;
        end else begin
            // Output capture uses pre-edge values, so it coexists with a load.
            if (w_out_en) begin
                r_y <= {r_acc[N-1:0], r_q};
            end
            if (w_load) begin
                r_m   <= {A[N-1], A};
                r_q   <= B;
                r_acc <= '0;
                r_q1  <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_q   <= w_q_next;
                r_q1  <= w_q1_next;
            end
        end
    end

    assign Q_LSB = {r_q[0], r_q1};
    assign Y     = r_y;

endmodule

// File: tb/tb_mult_with_no_sm.sv
// Randomized self-checking bench for the Booth multiplier datapath.
// A behavioural model tracks the datapath registers; full products are checked against plain multiplication.
module tb_mult_with_no_sm;

    localparam int N = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [4:0]       mult_control;
    logic [1:0]       Q_LSB;
    logic [2*N-1:0]   Y;

    int vectors;
    int miscompares;

    // Reference state
    logic signed [N:0]   m_m;
    logic signed [N:0]   m_acc;
    logic [N-1:0]        m_q;
    logic                m_q1;
    logic [2*N-1:0]      m_y;

    mult_with_no_sm #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .mult_control (mult_control),
        .Q_LSB        (Q_LSB),
        .Y            (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_apply(input logic [4:0] ctrl, input logic r);
        logic signed [N:0]       t;
        logic signed [2*N+1:0]   w;
        if (r) begin
            m_m = '0; m_acc = '0; m_q = '0; m_q1 = 1'b0; m_y = '0;
        end else begin
            if (ctrl[4]) m_y = {m_acc[N-1:0], m_q};
            if (ctrl[0]) begin
                m_m = {A[N-1], A}; m_q = B; m_acc = '0; m_q1 = 1'b0;
            end else begin
                t = m_acc;
                if (ctrl[1] && !ctrl[2]) t = m_acc + m_m;
                if (ctrl[2] && !ctrl[1]) t = m_acc - m_m;
                if (ctrl[3]) begin
                    w = {t, m_q, m_q1};
                    w = w >>> 1;
                    t = w[2*N+1:N+1];
                    m_q = w[N:1];
                    m_q1 = w[0];
                end
                m_acc = t;
            end
        end
    endtask

    task automatic tick(input logic [4:0] ctrl, input logic r);
        mult_control = ctrl;
        rst = r;
        model_apply(ctrl, r);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] booth_ctrl(input logic [1:0] pair);
        case (pair)
            2'b01:   return 5'b01010;
            2'b10:   return 5'b01100;
            default: return 5'b01000;
        endcase
    endfunction

    // Full multiply driven as the intended controller would; checks Y against the true product.
    task automatic run_mult(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                            input logic [2*N-1:0] expv, input string name);
        logic signed [2*N-1:0] prod;
        prod = a * b;
        A = a; B = b;
        tick(5'b00001, 1'b0);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (Q_LSB !== {m_q[0], m_q1}) begin
                $display("FAIL %s q_lsb step %0d: got %b want %b", name, i, Q_LSB, {m_q[0], m_q1});
                miscompares++;
            end
            tick(booth_ctrl({m_q[0], m_q1}), 1'b0);
        end
        tick(5'b10000, 1'b0);
        vectors++;
        if (Y !== prod) begin
            $display("FAIL %s product: got %h want %h", name, Y, prod);
            miscompares++;
        end
        vectors++;
        if (Y !== expv) begin
            $display("FAIL %s constant: got %h want %h", name, Y, expv);
            miscompares++;
        end
        tick(5'b00000, 1'b0);
    endtask

    task automatic test_reset();
        A = N'($urandom); B = N'($urandom);
        tick(5'($urandom), 1'b1);
        tick(5'($urandom), 1'b1);
        vectors++;
        if (Y !== 16'h0000 || Q_LSB !== 2'b00) begin
            $display("FAIL reset: got Y=%h Q_LSB=%b want 0000/00", Y, Q_LSB);
            miscompares++;
        end
        tick(5'b00000, 1'b0);
        tick(5'b00000, 1'b0);
        vectors++;
        if (Y !== 16'h0000 || Q_LSB !== 2'b00) begin
            $display("FAIL reset_hold: got Y=%h Q_LSB=%b want 0000/00", Y, Q_LSB);
            miscompares++;
        end
        tick(5'b10000, 1'b0);
        vectors++;
        if (Y !== 16'h0000) begin
            $display("FAIL reset_regs: got Y=%h want 0000", Y);
            miscompares++;
        end
    endtask

    task automatic test_products();
        run_mult(8'sd3,    8'sd5,    16'h000F, "pos_3x5");
        run_mult(-8'sd3,   8'sd5,    16'hFFF1, "neg3x5");
        run_mult(8'sd127,  -8'sd128, 16'hC080, "127xm128");
        run_mult(-8'sd128, -8'sd128, 16'h4000, "m128xm128");
        run_mult(8'sd0,    -8'sd1,   16'h0000, "0xm1");
    endtask

    task automatic test_control_rules();
        A = 8'd5; B = 8'h01;
        tick(5'b00001, 1'b0);
        vectors++;
        if (Q_LSB !== 2'b10) begin
            $display("FAIL load_b1_qlsb: got %b want 10", Q_LSB);
            miscompares++;
        end
        A = 8'd5; B = 8'h96;
        tick(5'b00001, 1'b0);
        tick(5'b01110, 1'b0);
        tick(5'b10000, 1'b0);
        vectors++;
        if (Y !== 16'h004B || Y !== m_y) begin
            $display("FAIL addsub_shift: got %h want 004b", Y);
            miscompares++;
        end
        A = 8'd5; B = 8'd3;
        tick(5'b00011, 1'b0);
        tick(5'b10000, 1'b0);
        vectors++;
        if (Y !== 16'h0003) begin
            $display("FAIL load_with_add: got %h want 0003", Y);
            miscompares++;
        end
        // add alone then out_en together with load: Y captures the pre-load accumulator
        tick(5'b00010, 1'b0);
        A = 8'd9; B = 8'd1;
        tick(5'b10001, 1'b0);
        vectors++;
        if (Y !== 16'h0503) begin
            $display("FAIL outen_with_load: got %h want 0503", Y);
            miscompares++;
        end
    endtask

    task automatic test_random_control();
        for (int i = 0; i < 60; i++) begin
            A = N'($urandom); B = N'($urandom);
            tick(5'($urandom), 1'b0);
            vectors++;
            if (Y !== m_y || Q_LSB !== {m_q[0], m_q1}) begin
                $display("FAIL rand_ctrl %0d: got Y=%h Q_LSB=%b want Y=%h Q_LSB=%b",
                         i, Y, Q_LSB, m_y, {m_q[0], m_q1});
                miscompares++;
            end
        end
        tick(5'b10000, 1'b0);
        vectors++;
        if (Y !== m_y) begin
            $display("FAIL rand_ctrl_flush: got %h want %h", Y, m_y);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        A = 8'd100; B = 8'hA5;
        tick(5'b00001, 1'b0);
        for (int i = 0; i < 4; i++) tick(booth_ctrl({m_q[0], m_q1}), 1'b0);
        tick(5'b11111, 1'b1);
        vectors++;
        if (Y !== 16'h0000 || Q_LSB !== 2'b00) begin
            $display("FAIL reset_mid: got Y=%h Q_LSB=%b want 0000/00", Y, Q_LSB);
            miscompares++;
        end
        tick(5'b00000, 1'b0);
        run_mult(8'sd7, -8'sd2, 16'hFFF2, "7xm2");
    endtask

    task automatic test_back_to_back();
        logic signed [N-1:0]   a;
        logic signed [N-1:0]   b;
        logic signed [2*N-1:0] p;
        for (int k = 0; k < 25; k++) begin
            a = N'($urandom); b = N'($urandom);
            p = a * b;
            run_mult(a, b, p, "rand_mult");
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        A = '0; B = '0;
        mult_control = '0;
        m_m = '0; m_acc = '0; m_q = '0; m_q1 = 1'b0; m_y = '0;
        test_reset();
        test_products();
        test_control_rules();
        test_random_control();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
